sync_fifo_reader: RTL and testbench

Read-side client for the synchronous FIFO: drives the FIFO read port (RD_EN, DATA_OUT, EMPTY) and re-presents the words as a valid/ready stream to a downstream consumer. It absorbs the FIFO's one-cycle read latency with a 2-entry skid buffer, so it sustains one word per cycle with no bubbles and never loses a word when the consumer stalls. It sits between the FIFO's read port and any stream sink, mirroring the FIFO's write-side driver.

---
 rtl/sync_fifo_pkg.sv | 17 +
 rtl/sync_fifo_reader_skid.sv | 73 +++++++
 rtl/sync_fifo_reader.sv | 65 ++++++
 tb/tb_sync_fifo_reader.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/sync_fifo_pkg.sv
// Shared types and constants for the synchronous FIFO and its read-side client.
package sync_fifo_pkg;

   localparam int unsigned FIFO_WIDTH = 8;
   localparam int unsigned SKID_DEPTH = 2;
   localparam int unsigned RD_LATENCY = 1;
   localparam int unsigned OCC_WIDTH  = $clog2(SKID_DEPTH + 1);
   localparam int unsigned PTR_WIDTH  = $clog2(SKID_DEPTH);

   // Encoding equals the number of buffered words.
   typedef enum logic [1:0] {
      BUF_EMPTY = 2'd0,
      BUF_ONE   = 2'd1,
      BUF_FULL  = 2'd2
   } buf_state_t;

endpackage

// File: rtl/sync_fifo_reader_skid.sv
// Two-entry FIFO-ordered skid buffer with a registered head word and valid flag.
module sync_fifo_reader_skid
   import sync_fifo_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = FIFO_WIDTH
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  push,
   input  logic [DATA_WIDTH-1:0] push_data,
   input  logic                  pop,
   input  logic                  flush,
   output logic                  head_valid,
   output logic [DATA_WIDTH-1:0] head_data,
   output logic [OCC_WIDTH-1:0]  occ_c
);

   buf_state_t            state_q, state_d;
   logic [PTR_WIDTH-1:0]  rd_ptr_q, rd_ptr_d;
   logic [PTR_WIDTH-1:0]  wr_ptr_q, wr_ptr_d;
   logic [DATA_WIDTH-1:0] mem_q [SKID_DEPTH];
   logic                  head_valid_d;
   logic [DATA_WIDTH-1:0] head_data_d;

   assign occ_c = OCC_WIDTH'(state_q);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= BUF_EMPTY;
         rd_ptr_q   <= '0;
         wr_ptr_q   <= '0;
         head_valid <= 1'b0;
         head_data  <= '0;
         for (int i = 0; i < int'(SKID_DEPTH); i++) mem_q[i] <= '0;
      end else begin
         state_q    <= state_d;
         rd_ptr_q   <= rd_ptr_d;
         wr_ptr_q   <= wr_ptr_d;
         head_valid <= head_valid_d;
         head_data  <= head_data_d;
         if (push) mem_q[wr_ptr_q] <= push_data;
      end
   end

   // Occupancy FSM; the head register is preloaded with the word that will be at rd_ptr next cycle.
   always_comb begin
      state_d  = state_q;
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      if (push) wr_ptr_d = PTR_WIDTH'(wr_ptr_q + 1'b1);
      if (pop)  rd_ptr_d = PTR_WIDTH'(rd_ptr_q + 1'b1);
      unique case (state_q)
         BUF_EMPTY: if (push) state_d = BUF_ONE;
         BUF_ONE: begin
            if (push && !pop)      state_d = BUF_FULL;
            else if (pop && !push) state_d = BUF_EMPTY;
         end
         BUF_FULL:  if (pop && !push) state_d = BUF_ONE;
         default:   state_d = BUF_EMPTY;
      endcase
      if (flush) begin
         state_d  = BUF_EMPTY;
         rd_ptr_d = '0;
         wr_ptr_d = '0;
      end
      head_data_d  = (push && (wr_ptr_q == rd_ptr_d)) ? push_data : mem_q[rd_ptr_d];
      head_valid_d = (state_d != BUF_EMPTY);
   end

   a_no_overflow: assert property (@(posedge clk) disable iff (rst)
      !(state_q == BUF_FULL && push && !pop && !flush));

endmodule

// File: rtl/sync_fifo_reader.sv
// FIFO read-port client: issues reads, tracks the in-flight word and presents a valid/ready stream.
module sync_fifo_reader
   import sync_fifo_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = FIFO_WIDTH,
   parameter int unsigned CNT_WIDTH  = 32
) (
   input  logic                  CLK,
   input  logic                  RST,
   output logic                  RD_EN,
   input  logic [DATA_WIDTH-1:0] DATA_OUT,
   input  logic                  EMPTY,
   output logic                  OUT_VALID,
   output logic [DATA_WIDTH-1:0] OUT_DATA,
   input  logic                  OUT_READY,
   input  logic                  FLUSH,
   output logic [CNT_WIDTH-1:0]  WORD_CNT
);

   localparam int unsigned PEND_WIDTH = OCC_WIDTH + 1;

   logic [RD_LATENCY-1:0] inflight_q;
   logic                  flush_q;
   logic                  inflight;
   logic                  pop;
   logic                  push;
   logic [OCC_WIDTH-1:0]  occ_c;
   logic [PEND_WIDTH-1:0] pending_c;

   assign inflight = inflight_q[RD_LATENCY-1];
   assign pop      = OUT_VALID && OUT_READY;
   // Words returning during or right after a flush belong to the discarded stream.
   assign push     = inflight && !FLUSH && !flush_q;

   // Words already owned (buffered or returning) after this cycle's pop.
   assign pending_c = PEND_WIDTH'(occ_c) + PEND_WIDTH'(inflight) - PEND_WIDTH'(pop);
   assign RD_EN     = !RST && !EMPTY && !FLUSH && (pending_c < PEND_WIDTH'(SKID_DEPTH));

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         inflight_q <= '0;
         flush_q    <= 1'b0;
         WORD_CNT   <= '0;
      end else begin
         inflight_q <= RD_LATENCY'(RD_EN);
         flush_q    <= FLUSH;
         if (pop) WORD_CNT <= WORD_CNT + CNT_WIDTH'(1);
      end
   end

   sync_fifo_reader_skid #(
      .DATA_WIDTH(DATA_WIDTH)
   ) u_skid (
      .clk       (CLK),
      .rst       (RST),
      .push      (push),
      .push_data (DATA_OUT),
      .pop       (pop),
      .flush     (FLUSH),
      .head_valid(OUT_VALID),
      .head_data (OUT_DATA),
      .occ_c     (occ_c)
   );

endmodule

// File: tb/tb_sync_fifo_reader.sv
// Directed bench for sync_fifo_reader: per-cycle vector table plus stream/reset/wrap sequences.
module tb_sync_fifo_reader;

   logic       CLK;
   logic       RST;
   logic       RD_EN;
   logic [7:0] DATA_OUT;
   logic       EMPTY;
   logic       OUT_VALID;
   logic [7:0] OUT_DATA;
   logic       OUT_READY;
   logic       FLUSH;
   logic [31:0] WORD_CNT;
   logic       rd_en4;
   logic       out_valid4;
   logic [7:0] out_data4;
   logic [3:0] word_cnt4;

   int n_pass  = 0;
   int n_total = 0;

   // FIFO model: array plus indices; initial block owns wr_idx, the read process owns rd_idx.
   logic [7:0] fifo_mem [256];
   logic [7:0] wr_idx = 8'd0;
   logic [7:0] rd_idx = 8'd0;
   int         underflow = 0;

   assign EMPTY = (rd_idx == wr_idx);

   sync_fifo_reader dut (
      .CLK(CLK), .RST(RST), .RD_EN(RD_EN), .DATA_OUT(DATA_OUT), .EMPTY(EMPTY),
      .OUT_VALID(OUT_VALID), .OUT_DATA(OUT_DATA), .OUT_READY(OUT_READY),
      .FLUSH(FLUSH), .WORD_CNT(WORD_CNT)
   );

   sync_fifo_reader #(.CNT_WIDTH(4)) dut4 (
      .CLK(CLK), .RST(RST), .RD_EN(rd_en4), .DATA_OUT(DATA_OUT), .EMPTY(EMPTY),
      .OUT_VALID(out_valid4), .OUT_DATA(out_data4), .OUT_READY(OUT_READY),
      .FLUSH(FLUSH), .WORD_CNT(word_cnt4)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   initial DATA_OUT = 8'h00;
   always @(posedge CLK) begin
      if (RD_EN) begin
         if (EMPTY) underflow <= underflow + 1;
         else begin
            DATA_OUT <= fifo_mem[rd_idx];
            rd_idx   <= rd_idx + 8'd1;
         end
      end
   end

   typedef struct {
      int          nload;
      logic [23:0] words;
      logic        rdy;
      logic        flush;
      logic        e_rd;
      logic        e_v;
      logic        chk_d;
      logic [7:0]  e_d;
      int          e_cnt;
   } vec_t;

   vec_t tbl [24];

   function automatic vec_t mk(int nload, logic [23:0] words, logic rdy, logic flush,
                               logic e_rd, logic e_v, logic chk_d, logic [7:0] e_d, int e_cnt);
      vec_t v;
      v.nload = nload; v.words = words; v.rdy = rdy; v.flush = flush;
      v.e_rd = e_rd; v.e_v = e_v; v.chk_d = chk_d; v.e_d = e_d; v.e_cnt = e_cnt;
      return v;
   endfunction

   task automatic check(input logic ok, input string name, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (ok) n_pass++;
      else $display("FAIL %s: actual %0h required %0h (t=%0t)", name, act, exp, $time);
   endtask

   task automatic cyc();
      @(posedge CLK);
      #1;
   endtask

   task automatic load(input logic [7:0] w);
      fifo_mem[wr_idx] = w;
      wr_idx = wr_idx + 8'd1;
   endtask

   task automatic do_reset();
      cyc();
      RST = 1'b1; OUT_READY = 1'b0; FLUSH = 1'b0;
      cyc();
      wr_idx = rd_idx;
      cyc();
      RST = 1'b0;
   endtask

   // Streams n words from base; ready pattern is lo cycles low then hi cycles high (lo==0: always high).
   task automatic run_stream(input int n, input logic [7:0] base, input int lo, input int hi, input logic chk_gap);
      int k = 0, c = 0, first = -1, last = -1, outst = 0, ovf = 0;
      logic rd, pop;
      cyc();
      for (int i = 0; i < n; i++) load(base + 8'(i));
      while (k < n && c < 400) begin
         OUT_READY = (lo == 0) ? 1'b1 : ((c % (lo + hi)) >= lo);
         @(negedge CLK);
         rd  = RD_EN;
         pop = OUT_VALID && OUT_READY;
         if (rd && (outst - int'(pop)) >= 2) ovf++;
         if (pop) begin
            check(OUT_DATA == base + 8'(k), "stream_data", 64'(OUT_DATA), 64'(base + 8'(k)));
            if (first < 0) first = c;
            last = c;
            k++;
         end
         outst += int'(rd) - int'(pop);
         c++;
         cyc();
      end
      OUT_READY = 1'b0;
      check(k == n, "stream_count", 64'(k), 64'(n));
      if (chk_gap) check(last - first == n - 1, "stream_gapless", 64'(last - first), 64'(n - 1));
      check(ovf == 0, "rd_en_when_full", 64'(ovf), 64'd0);
      check(WORD_CNT == 32'(n), "word_cnt", 64'(WORD_CNT), 64'(n));
      check(word_cnt4 == 4'(n), "word_cnt4", 64'(word_cnt4), 64'(4'(n)));
   endtask

   initial begin
      RST = 1'b1; OUT_READY = 1'b0; FLUSH = 1'b0;
      #2;
      check(RD_EN == 1'b0, "reset_rd_en", 64'(RD_EN), 64'd0);
      check(OUT_VALID == 1'b0, "reset_valid", 64'(OUT_VALID), 64'd0);
      check(OUT_DATA == 8'h00, "reset_data", 64'(OUT_DATA), 64'd0);
      check(WORD_CNT == 32'd0, "reset_cnt", 64'(WORD_CNT), 64'd0);
      do_reset();

      //            nload words      rdy flush | rd v  chk data  cnt
      tbl[0]  = mk(0, 24'h0,       0, 0,   0, 0, 0, 8'h00, 0);
      tbl[1]  = mk(1, 24'h00005A,  0, 0,   1, 0, 0, 8'h00, 0);
      tbl[2]  = mk(0, 24'h0,       0, 0,   0, 0, 0, 8'h00, 0);
      tbl[3]  = mk(0, 24'h0,       0, 0,   0, 1, 1, 8'h5A, 0);
      tbl[4]  = mk(0, 24'h0,       0, 0,   0, 1, 1, 8'h5A, 0);
      tbl[5]  = mk(0, 24'h0,       1, 0,   0, 1, 1, 8'h5A, 0);
      tbl[6]  = mk(0, 24'h0,       1, 0,   0, 0, 0, 8'h00, 1);
      tbl[7]  = mk(0, 24'h0,       1, 0,   0, 0, 0, 8'h00, 1);
      tbl[8]  = mk(3, 24'h332211,  0, 0,   1, 0, 0, 8'h00, 1);
      tbl[9]  = mk(0, 24'h0,       0, 0,   1, 0, 0, 8'h00, 1);
      tbl[10] = mk(0, 24'h0,       0, 1,   0, 1, 1, 8'h11, 1);
      tbl[11] = mk(0, 24'h0,       0, 0,   1, 0, 0, 8'h00, 1);
      tbl[12] = mk(0, 24'h0,       0, 0,   0, 0, 0, 8'h00, 1);
      tbl[13] = mk(0, 24'h0,       1, 0,   0, 1, 1, 8'h33, 1);
      tbl[14] = mk(0, 24'h0,       1, 0,   0, 0, 0, 8'h00, 2);
      tbl[15] = mk(3, 24'h665544,  0, 0,   1, 0, 0, 8'h00, 2);
      tbl[16] = mk(0, 24'h0,       0, 0,   1, 0, 0, 8'h00, 2);
      tbl[17] = mk(0, 24'h0,       0, 0,   0, 1, 1, 8'h44, 2);
      tbl[18] = mk(0, 24'h0,       0, 0,   0, 1, 1, 8'h44, 2);
      tbl[19] = mk(0, 24'h0,       1, 1,   0, 1, 1, 8'h44, 2);
      tbl[20] = mk(0, 24'h0,       0, 0,   1, 0, 0, 8'h00, 3);
      tbl[21] = mk(0, 24'h0,       0, 0,   0, 0, 0, 8'h00, 3);
      tbl[22] = mk(0, 24'h0,       1, 0,   0, 1, 1, 8'h66, 3);
      tbl[23] = mk(0, 24'h0,       0, 0,   0, 0, 0, 8'h00, 4);

      for (int i = 0; i < 24; i++) begin
         cyc();
         for (int j = 0; j < tbl[i].nload; j++) load(tbl[i].words[8*j +: 8]);
         OUT_READY = tbl[i].rdy;
         FLUSH     = tbl[i].flush;
         @(negedge CLK);
         check(RD_EN == tbl[i].e_rd, $sformatf("vec%0d_rd_en", i), 64'(RD_EN), 64'(tbl[i].e_rd));
         check(OUT_VALID == tbl[i].e_v, $sformatf("vec%0d_valid", i), 64'(OUT_VALID), 64'(tbl[i].e_v));
         if (tbl[i].chk_d)
            check(OUT_DATA == tbl[i].e_d, $sformatf("vec%0d_data", i), 64'(OUT_DATA), 64'(tbl[i].e_d));
         check(WORD_CNT == 32'(tbl[i].e_cnt), $sformatf("vec%0d_cnt", i), 64'(WORD_CNT), 64'(tbl[i].e_cnt));
         check(word_cnt4 == 4'(tbl[i].e_cnt), $sformatf("vec%0d_cnt4", i), 64'(word_cnt4), 64'(tbl[i].e_cnt));
      end
      FLUSH = 1'b0;

      // Reset asserted with the buffer full; then restart from the remaining FIFO words.
      cyc();
      OUT_READY = 1'b0;
      for (int i = 0; i < 4; i++) load(8'h70 + 8'(i));
      repeat (5) cyc();
      @(negedge CLK);
      check(OUT_VALID == 1'b1 && OUT_DATA == 8'h70, "full_before_reset", 64'({OUT_VALID, OUT_DATA}), 64'h170);
      cyc();
      RST = 1'b1;
      #1;
      check(RD_EN == 1'b0, "midrst_rd_en", 64'(RD_EN), 64'd0);
      check(OUT_VALID == 1'b0, "midrst_valid", 64'(OUT_VALID), 64'd0);
      check(OUT_DATA == 8'h00, "midrst_data", 64'(OUT_DATA), 64'd0);
      check(WORD_CNT == 32'd0, "midrst_cnt", 64'(WORD_CNT), 64'd0);
      cyc();
      cyc();
      RST = 1'b0;
      @(negedge CLK);
      check(RD_EN == 1'b1, "post_rst_rd_en", 64'(RD_EN), 64'd1);
      cyc();
      @(negedge CLK);
      check(OUT_VALID == 1'b0, "post_rst_valid_n1", 64'(OUT_VALID), 64'd0);
      cyc();
      @(negedge CLK);
      check(OUT_VALID == 1'b1 && OUT_DATA == 8'h72, "post_rst_first", 64'({OUT_VALID, OUT_DATA}), 64'h172);

      do_reset();
      run_stream(16, 8'h01, 0, 0, 1'b1);
      do_reset();
      run_stream(16, 8'hA0, 3, 2, 1'b0);
      do_reset();
      run_stream(17, 8'hC0, 0, 0, 1'b1);

      check(underflow == 0, "rd_en_while_empty", 64'(underflow), 64'd0);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: actual timeout required finish");
      $fatal(1, "watchdog");
   end

endmodule
